// File: rtl/fwrisc_decode_pkg.sv
// Shared encodings for the fwrisc decode stage: opcodes, operation classes,
// sub-operation codes and the registered execute payload.
package fwrisc_decode_pkg;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned RADDR_W = 5;
   localparam int unsigned CODE_W  = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RDREG = 2'd1,
      ST_VALID = 2'd2
   } state_e;

   typedef enum logic [CODE_W-1:0] {
      CLS_ALU     = 4'd0,
      CLS_BRANCH  = 4'd1,
      CLS_LOAD    = 4'd2,
      CLS_STORE   = 4'd3,
      CLS_JAL     = 4'd4,
      CLS_JALR    = 4'd5,
      CLS_LUI     = 4'd6,
      CLS_AUIPC   = 4'd7,
      CLS_SYSTEM  = 4'd8,
      CLS_ILLEGAL = 4'd9
   } op_class_e;

   typedef enum logic [CODE_W-1:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } alu_op_e;

   typedef enum logic [CODE_W-1:0] {
      BR_EQ  = 4'd0,
      BR_NE  = 4'd1,
      BR_LT  = 4'd2,
      BR_GE  = 4'd3,
      BR_LTU = 4'd4,
      BR_GEU = 4'd5
   } br_op_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef struct packed {
      logic [CODE_W-1:0]  op_class;
      logic [CODE_W-1:0]  op_sub;
      logic [XLEN-1:0]    op_a;
      logic [XLEN-1:0]    op_b;
      logic [XLEN-1:0]    op_c;
      logic [RADDR_W-1:0] rd;
      logic               instr_c;
   } dec_out_t;

   // funct3 to ALU operation; alt selects SUB/SRA
   function automatic logic [CODE_W-1:0] alu_sub(input logic [2:0] funct3, input logic alt);
      logic [CODE_W-1:0] op;
      case (funct3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/fwrisc_decode_imm.sv
// Combinational RV32I immediate generator; every format sign-extended to XLEN.
module fwrisc_decode_imm
   import fwrisc_decode_pkg::*;
(
   input  logic [31:7]     instr_i,
   output logic [XLEN-1:0] imm_i_o,
   output logic [XLEN-1:0] imm_s_o,
   output logic [XLEN-1:0] imm_b_o,
   output logic [XLEN-1:0] imm_u_o,
   output logic [XLEN-1:0] imm_j_o
);

   assign imm_i_o = {{20{instr_i[31]}}, instr_i[31:20]};
   assign imm_s_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
   assign imm_b_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                     instr_i[11:8], 1'b0};
   assign imm_u_o = {instr_i[31:12], 12'b0};
   assign imm_j_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                     instr_i[30:21], 1'b0};

endmodule

// File: rtl/fwrisc_decode.sv
// fwrisc decode stage: latches an instruction from fetch, reads the register
// file, and presents registered operands/control to execute via valid/ready.
module fwrisc_decode
   import fwrisc_decode_pkg::*;
#(
   parameter bit ENABLE_FWD = 1'b1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               fetch_valid,
   input  logic [XLEN-1:0]    instr,
   input  logic               instr_c,
   input  logic [XLEN-1:0]    pc,
   output logic               decode_complete,
   output logic [RADDR_W-1:0] rs1_raddr,
   output logic [RADDR_W-1:0] rs2_raddr,
   input  logic [XLEN-1:0]    rs1_rdata,
   input  logic [XLEN-1:0]    rs2_rdata,
   input  logic               rd_wen,
   input  logic [RADDR_W-1:0] rd_waddr,
   input  logic [XLEN-1:0]    rd_wdata,
   output logic               decode_valid,
   input  logic               exec_ready,
   output logic [XLEN-1:0]    op_a,
   output logic [XLEN-1:0]    op_b,
   output logic [XLEN-1:0]    op_c,
   output logic [RADDR_W-1:0] rd,
   output logic [CODE_W-1:0]  op_class,
   output logic [CODE_W-1:0]  op_sub,
   output logic               instr_c_o
);

   state_e             state_q, state_d;
   logic [XLEN-1:0]    instr_q, pc_q;
   logic               instr_c_q;
   logic [RADDR_W-1:0] rs1_q, rs2_q;
   logic               valid_q, valid_d;
   dec_out_t           out_q, out_d, dec;
   logic               latch_en, complete_c, illegal;
   logic [XLEN-1:0]    rs1_val, rs2_val, link;
   logic [XLEN-1:0]    imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [6:0]         opcode, funct7;
   logic [2:0]         funct3;

   fwrisc_decode_imm u_imm (
      .instr_i (instr_q[31:7]),
      .imm_i_o (imm_i),
      .imm_s_o (imm_s),
      .imm_b_o (imm_b),
      .imm_u_o (imm_u),
      .imm_j_o (imm_j)
   );

   assign opcode = instr_q[6:0];
   assign funct3 = instr_q[14:12];
   assign funct7 = instr_q[31:25];
   assign link   = XLEN'(pc_q + (instr_c_q ? 32'd2 : 32'd4));

   // Addresses go out straight from fetch in IDLE so the synchronous read lands in RDREG
   assign rs1_raddr = (state_q == ST_IDLE && fetch_valid) ? instr[19:15] : rs1_q;
   assign rs2_raddr = (state_q == ST_IDLE && fetch_valid) ? instr[24:20] : rs2_q;

   // Operand read with x0 forced to zero and optional writeback bypass
   always_comb begin
      rs1_val = rs1_rdata;
      rs2_val = rs2_rdata;
      if (rs1_q == '0)
         rs1_val = '0;
      else if (ENABLE_FWD && rd_wen && rd_waddr == rs1_q)
         rs1_val = rd_wdata;
      if (rs2_q == '0)
         rs2_val = '0;
      else if (ENABLE_FWD && rd_wen && rd_waddr == rs2_q)
         rs2_val = rd_wdata;
   end

   // Instruction decode into the execute payload
   always_comb begin
      dec         = '0;
      illegal     = 1'b0;
      dec.instr_c = instr_c_q;
      dec.rd      = instr_q[11:7];
      if (instr_q[1:0] != 2'b11) begin
         illegal = 1'b1;
      end else begin
         case (opcode)
            OPC_OP: begin
               dec.op_class = CLS_ALU;
               dec.op_sub   = alu_sub(funct3, funct7[5]);
               dec.op_a     = rs1_val;
               dec.op_b     = rs2_val;
               if (funct7 == 7'b0100000)
                  illegal = !(funct3 == 3'b000 || funct3 == 3'b101);
               else if (funct7 != 7'b0000000)
                  illegal = 1'b1;
            end
            OPC_OP_IMM: begin
               dec.op_class = CLS_ALU;
               dec.op_sub   = alu_sub(funct3, 1'b0);
               dec.op_a     = rs1_val;
               dec.op_b     = imm_i;
               if (funct3 == 3'b001 || funct3 == 3'b101) begin
                  dec.op_sub = alu_sub(funct3, funct7[5]);
                  dec.op_b   = XLEN'(instr_q[24:20]);
                  if (funct7 == 7'b0100000)
                     illegal = (funct3 != 3'b101);
                  else if (funct7 != 7'b0000000)
                     illegal = 1'b1;
               end
            end
            OPC_LOAD: begin
               dec.op_class = CLS_LOAD;
               dec.op_sub   = CODE_W'(funct3);
               dec.op_a     = rs1_val;
               dec.op_b     = imm_i;
               illegal      = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
            end
            OPC_STORE: begin
               dec.op_class = CLS_STORE;
               dec.op_sub   = CODE_W'(funct3);
               dec.op_a     = rs1_val;
               dec.op_b     = imm_s;
               dec.op_c     = rs2_val;
               dec.rd       = '0;
               illegal      = (funct3 > 3'd2);
            end
            OPC_BRANCH: begin
               dec.op_class = CLS_BRANCH;
               dec.op_a     = rs1_val;
               dec.op_b     = rs2_val;
               dec.op_c     = XLEN'(pc_q + imm_b);
               dec.rd       = '0;
               case (funct3)
                  3'b000:  dec.op_sub = BR_EQ;
                  3'b001:  dec.op_sub = BR_NE;
                  3'b100:  dec.op_sub = BR_LT;
                  3'b101:  dec.op_sub = BR_GE;
                  3'b110:  dec.op_sub = BR_LTU;
                  3'b111:  dec.op_sub = BR_GEU;
                  default: illegal    = 1'b1;
               endcase
            end
            OPC_JAL: begin
               dec.op_class = CLS_JAL;
               dec.op_a     = pc_q;
               dec.op_b     = imm_j;
               dec.op_c     = link;
            end
            OPC_JALR: begin
               dec.op_class = CLS_JALR;
               dec.op_a     = rs1_val;
               dec.op_b     = imm_i;
               dec.op_c     = link;
               illegal      = (funct3 != 3'b000);
            end
            OPC_LUI: begin
               dec.op_class = CLS_LUI;
               dec.op_b     = imm_u;
            end
            OPC_AUIPC: begin
               dec.op_class = CLS_AUIPC;
               dec.op_a     = pc_q;
               dec.op_b     = imm_u;
            end
            OPC_SYSTEM: begin
               dec.op_class = CLS_SYSTEM;
               dec.op_sub   = CODE_W'(funct3);
               dec.op_a     = rs1_val;
               dec.op_b     = XLEN'(instr_q[31:20]);
               illegal      = (funct3 == 3'b100);
            end
            default: illegal = 1'b1;
         endcase
      end
      if (illegal) begin
         dec          = '0;
         dec.op_class = CLS_ILLEGAL;
         dec.instr_c  = instr_c_q;
      end
   end

   // Next-state and output-register logic
   always_comb begin
      state_d    = state_q;
      valid_d    = valid_q;
      out_d      = out_q;
      latch_en   = 1'b0;
      complete_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (fetch_valid) begin
               latch_en = 1'b1;
               state_d  = ST_RDREG;
            end
         end
         ST_RDREG: begin
            out_d   = dec;
            valid_d = 1'b1;
            state_d = ST_VALID;
         end
         ST_VALID: begin
            if (exec_ready) begin
               complete_c = 1'b1;
               valid_d    = 1'b0;
               state_d    = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         valid_q   <= 1'b0;
         out_q     <= '0;
         instr_q   <= '0;
         instr_c_q <= 1'b0;
         pc_q      <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         out_q   <= out_d;
         if (latch_en) begin
            instr_q   <= instr;
            instr_c_q <= instr_c;
            pc_q      <= pc;
            rs1_q     <= instr[19:15];
            rs2_q     <= instr[24:20];
         end
      end
   end

   // A handshake coinciding with reset is dropped, so no release to fetch
   assign decode_complete = complete_c & reset;
   assign decode_valid    = valid_q;
   assign op_a            = out_q.op_a;
   assign op_b            = out_q.op_b;
   assign op_c            = out_q.op_c;
   assign rd              = out_q.rd;
   assign op_class        = out_q.op_class;
   assign op_sub          = out_q.op_sub;
   assign instr_c_o       = out_q.instr_c;

endmodule

// File: tb/tb_fwrisc_decode.sv
// Directed self-checking bench for fwrisc_decode: a vector table run through
// the full handshake plus hand-written backpressure and reset-abort sequences.
module tb_fwrisc_decode;

   logic        clock = 1'b0;
   logic        reset;
   logic        fetch_valid;
   logic [31:0] instr;
   logic        instr_c;
   logic [31:0] pc;
   logic        decode_complete;
   logic [4:0]  rs1_raddr, rs2_raddr;
   logic [31:0] rs1_rdata, rs2_rdata;
   logic        rd_wen;
   logic [4:0]  rd_waddr;
   logic [31:0] rd_wdata;
   logic        decode_valid;
   logic        exec_ready;
   logic [31:0] op_a, op_b, op_c;
   logic [4:0]  rd;
   logic [3:0]  op_class, op_sub;
   logic        instr_c_o;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [31:0] instr;
      logic        ic;
      logic [31:0] pc;
      logic [31:0] r1;
      logic [31:0] r2;
      logic        fwd;
      logic [4:0]  fwa;
      logic [31:0] fwd_d;
      logic [3:0]  cls;
      logic [3:0]  sub;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic [4:0]  rd;
   } vec_t;

   localparam int NVEC = 20;
   vec_t vecs[NVEC];

   fwrisc_decode #(.ENABLE_FWD(1'b1)) dut (
      .clock           (clock),
      .reset           (reset),
      .fetch_valid     (fetch_valid),
      .instr           (instr),
      .instr_c         (instr_c),
      .pc              (pc),
      .decode_complete (decode_complete),
      .rs1_raddr       (rs1_raddr),
      .rs2_raddr       (rs2_raddr),
      .rs1_rdata       (rs1_rdata),
      .rs2_rdata       (rs2_rdata),
      .rd_wen          (rd_wen),
      .rd_waddr        (rd_waddr),
      .rd_wdata        (rd_wdata),
      .decode_valid    (decode_valid),
      .exec_ready      (exec_ready),
      .op_a            (op_a),
      .op_b            (op_b),
      .op_c            (op_c),
      .rd              (rd),
      .op_class        (op_class),
      .op_sub          (op_sub),
      .instr_c_o       (instr_c_o)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input int idx, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s [%0d]: got 0x%08h, expected 0x%08h", name, idx, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] i, input logic ic, input logic [31:0] p,
                               input logic [31:0] r1, input logic [31:0] r2,
                               input logic fwd, input logic [4:0] fwa, input logic [31:0] fwd_d,
                               input logic [3:0] cls, input logic [3:0] sub,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] c, input logic [4:0] r);
      vec_t v;
      v.instr = i;   v.ic  = ic;  v.pc = p;    v.r1 = r1; v.r2 = r2;
      v.fwd   = fwd; v.fwa = fwa; v.fwd_d = fwd_d;
      v.cls   = cls; v.sub = sub; v.a = a; v.b = b; v.c = c; v.rd = r;
      return v;
   endfunction

   // One instruction through IDLE -> RDREG -> VALID -> IDLE; starts and ends at a negedge in IDLE
   task automatic run_vec(input vec_t v, input int idx);
      fetch_valid = 1'b1;
      instr       = v.instr;
      instr_c     = v.ic;
      pc          = v.pc;
      rs1_rdata   = v.r1;
      rs2_rdata   = v.r2;
      exec_ready  = 1'b0;
      rd_wen      = 1'b0;
      #1;
      check("rs1_raddr_idle", idx, 32'(rs1_raddr), 32'(v.instr[19:15]));
      check("rs2_raddr_idle", idx, 32'(rs2_raddr), 32'(v.instr[24:20]));
      @(negedge clock);
      fetch_valid = 1'b0;
      instr       = 32'h0000_0013;
      rd_wen      = v.fwd;
      rd_waddr    = v.fwa;
      rd_wdata    = v.fwd_d;
      #1;
      check("rs1_raddr_rdreg", idx, 32'(rs1_raddr), 32'(v.instr[19:15]));
      check("rs2_raddr_rdreg", idx, 32'(rs2_raddr), 32'(v.instr[24:20]));
      check("valid_rdreg", idx, 32'(decode_valid), 32'd0);
      @(negedge clock);
      rd_wen = 1'b0;
      #1;
      check("valid", idx, 32'(decode_valid), 32'd1);
      check("op_class", idx, 32'(op_class), 32'(v.cls));
      check("op_sub", idx, 32'(op_sub), 32'(v.sub));
      check("op_a", idx, op_a, v.a);
      check("op_b", idx, op_b, v.b);
      check("op_c", idx, op_c, v.c);
      check("rd", idx, 32'(rd), 32'(v.rd));
      check("instr_c_o", idx, 32'(instr_c_o), 32'(v.ic));
      check("complete_wait", idx, 32'(decode_complete), 32'd0);
      exec_ready = 1'b1;
      #1;
      check("complete", idx, 32'(decode_complete), 32'd1);
      @(negedge clock);
      exec_ready = 1'b0;
      #1;
      check("valid_after", idx, 32'(decode_valid), 32'd0);
      check("complete_after", idx, 32'(decode_complete), 32'd0);
   endtask

   initial begin
      //             instr         c  pc        r1            r2            fw fwa    fwd_d         cls   sub   a             b             c            rd
      vecs[0]  = mk(32'h00510093, 0, 32'h000, 32'h10,       32'h22,       0, 5'd0, 32'h0,        4'd0, 4'd0, 32'h10,       32'h5,        32'h0,       5'd1);
      vecs[1]  = mk(32'h123452B7, 0, 32'h000, 32'h11,       32'h22,       0, 5'd0, 32'h0,        4'd6, 4'd0, 32'h0,        32'h12345000, 32'h0,       5'd5);
      vecs[2]  = mk(32'h008000EF, 0, 32'h100, 32'h11,       32'h22,       0, 5'd0, 32'h0,        4'd4, 4'd0, 32'h100,      32'h8,        32'h104,     5'd1);
      vecs[3]  = mk(32'h008000EF, 1, 32'h100, 32'h11,       32'h22,       0, 5'd0, 32'h0,        4'd4, 4'd0, 32'h100,      32'h8,        32'h102,     5'd1);
      vecs[4]  = mk(32'h00510093, 0, 32'h000, 32'h10,       32'h22,       1, 5'd2, 32'hDEADBEEF, 4'd0, 4'd0, 32'hDEADBEEF, 32'h5,        32'h0,       5'd1);
      vecs[5]  = mk(32'h00500093, 0, 32'h000, 32'hFFFFFFFF, 32'h22,       0, 5'd0, 32'h0,        4'd0, 4'd0, 32'h0,        32'h5,        32'h0,       5'd1);
      vecs[6]  = mk(32'h002081B3, 0, 32'h000, 32'h11,       32'h22,       0, 5'd0, 32'h0,        4'd0, 4'd0, 32'h11,       32'h22,       32'h0,       5'd3);
      vecs[7]  = mk(32'h402081B3, 0, 32'h000, 32'h11,       32'h22,       0, 5'd0, 32'h0,        4'd0, 4'd1, 32'h11,       32'h22,       32'h0,       5'd3);
      vecs[8]  = mk(32'hFE20CEE3, 0, 32'h200, 32'h11,       32'h22,       0, 5'd0, 32'h0,        4'd1, 4'd2, 32'h11,       32'h22,       32'h1FC,     5'd0);
      vecs[9]  = mk(32'hFF80A203, 0, 32'h000, 32'h11,       32'h22,       0, 5'd0, 32'h0,        4'd2, 4'd2, 32'h11,       32'hFFFFFFF8, 32'h0,       5'd4);
      vecs[10] = mk(32'h0020A623, 0, 32'h000, 32'h11,       32'h22,       0, 5'd0, 32'h0,        4'd3, 4'd2, 32'h11,       32'hC,        32'h22,      5'd0);
      vecs[11] = mk(32'h004100E7, 0, 32'h300, 32'h11,       32'h22,       0, 5'd0, 32'h0,        4'd5, 4'd0, 32'h11,       32'h4,        32'h304,     5'd1);
      vecs[12] = mk(32'h00001397, 0, 32'h400, 32'h11,       32'h22,       0, 5'd0, 32'h0,        4'd7, 4'd0, 32'h400,      32'h1000,     32'h0,       5'd7);
      vecs[13] = mk(32'h300092F3, 0, 32'h000, 32'h11,       32'h22,       0, 5'd0, 32'h0,        4'd8, 4'd1, 32'h11,       32'h300,      32'h0,       5'd5);
      vecs[14] = mk(32'h00315093, 0, 32'h000, 32'h11,       32'h22,       0, 5'd0, 32'h0,        4'd0, 4'd6, 32'h11,       32'h3,        32'h0,       5'd1);
      vecs[15] = mk(32'h00000000, 0, 32'h000, 32'h11,       32'h22,       0, 5'd0, 32'h0,        4'd9, 4'd0, 32'h0,        32'h0,        32'h0,       5'd0);
      vecs[16] = mk(32'h0000707F, 0, 32'h000, 32'h11,       32'h22,       0, 5'd0, 32'h0,        4'd9, 4'd0, 32'h0,        32'h0,        32'h0,       5'd0);
      vecs[17] = mk(32'h022081B3, 0, 32'h000, 32'h11,       32'h22,       0, 5'd0, 32'h0,        4'd9, 4'd0, 32'h0,        32'h0,        32'h0,       5'd0);
      vecs[18] = mk(32'h002081B3, 0, 32'h000, 32'h11,       32'h22,       1, 5'd2, 32'hCAFEF00D, 4'd0, 4'd0, 32'h11,       32'hCAFEF00D, 32'h0,       5'd3);
      vecs[19] = mk(32'h00500093, 0, 32'h000, 32'hFFFFFFFF, 32'h22,       1, 5'd0, 32'h12345678, 4'd0, 4'd0, 32'h0,        32'h5,        32'h0,       5'd1);

      reset       = 1'b0;
      fetch_valid = 1'b0;
      instr       = '0;
      instr_c     = 1'b0;
      pc          = '0;
      rs1_rdata   = '0;
      rs2_rdata   = '0;
      rd_wen      = 1'b0;
      rd_waddr    = '0;
      rd_wdata    = '0;
      exec_ready  = 1'b0;
      repeat (2) @(negedge clock);
      #1;
      check("reset_valid", 0, 32'(decode_valid), 32'd0);
      check("reset_complete", 0, 32'(decode_complete), 32'd0);
      check("reset_op_a", 0, op_a, 32'd0);
      check("reset_class", 0, 32'(op_class), 32'd0);
      check("reset_rd", 0, 32'(rd), 32'd0);
      reset = 1'b1;
      @(negedge clock);

      for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

      // Backpressure: hold in VALID for three cycles while fetch tries to push another instruction
      fetch_valid = 1'b1;
      instr       = 32'h00510093;
      instr_c     = 1'b0;
      pc          = 32'h0;
      rs1_rdata   = 32'h10;
      exec_ready  = 1'b0;
      @(negedge clock);
      fetch_valid = 1'b0;
      @(negedge clock);
      for (int k = 0; k < 3; k++) begin
         #1;
         check("bp_valid", k, 32'(decode_valid), 32'd1);
         check("bp_complete", k, 32'(decode_complete), 32'd0);
         check("bp_op_a", k, op_a, 32'h10);
         check("bp_op_b", k, op_b, 32'h5);
         check("bp_rd", k, 32'(rd), 32'd1);
         fetch_valid = 1'b1;
         instr       = 32'h123452B7;
         @(negedge clock);
      end
      fetch_valid = 1'b0;
      exec_ready  = 1'b1;
      #1;
      check("bp_release", 0, 32'(decode_complete), 32'd1);
      check("bp_release_a", 0, op_a, 32'h10);
      @(negedge clock);
      #1;
      check("bp_idle_valid", 0, 32'(decode_valid), 32'd0);
      check("bp_idle_complete", 0, 32'(decode_complete), 32'd0);
      @(negedge clock);
      #1;
      check("bp_idle_complete", 1, 32'(decode_complete), 32'd0);
      exec_ready = 1'b0;

      // Reset while in RDREG drops the instruction
      fetch_valid = 1'b1;
      instr       = 32'h00510093;
      rs1_rdata   = 32'h10;
      @(negedge clock);
      fetch_valid = 1'b0;
      reset       = 1'b0;
      @(negedge clock);
      #1;
      check("rst_rdreg_valid", 0, 32'(decode_valid), 32'd0);
      check("rst_rdreg_complete", 0, 32'(decode_complete), 32'd0);
      check("rst_rdreg_op_a", 0, op_a, 32'd0);
      reset      = 1'b1;
      exec_ready = 1'b1;
      @(negedge clock);
      #1;
      check("rst_rdreg_after_valid", 0, 32'(decode_valid), 32'd0);
      check("rst_rdreg_after_complete", 0, 32'(decode_complete), 32'd0);
      exec_ready = 1'b0;

      // Reset while in VALID, coinciding with exec_ready
      fetch_valid = 1'b1;
      instr       = 32'h00510093;
      @(negedge clock);
      fetch_valid = 1'b0;
      @(negedge clock);
      #1;
      check("rst_valid_pre", 0, 32'(decode_valid), 32'd1);
      reset      = 1'b0;
      exec_ready = 1'b1;
      #1;
      check("rst_valid_complete", 0, 32'(decode_complete), 32'd0);
      @(negedge clock);
      #1;
      check("rst_valid_valid", 0, 32'(decode_valid), 32'd0);
      check("rst_valid_complete", 1, 32'(decode_complete), 32'd0);
      reset = 1'b1;
      @(negedge clock);
      #1;
      check("rst_valid_after", 0, 32'(decode_complete), 32'd0);
      check("rst_valid_after_valid", 0, 32'(decode_valid), 32'd0);
      exec_ready = 1'b0;
      @(negedge clock);

      run_vec(vecs[0], 100);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
